noc_resp_merge: RTL and testbench

NMU response-side reassembler. The NMU address map may split one AXI burst into two NoC sub-requests: part0 (lower address) and part1, each sent to its own destination (PS/PL). This block takes the split descriptor and collects read beats or write responses from both destinations. It returns them to the AXI slave port as one burst, in order: all part0 beats, then all part1 beats, with a single RLAST and a single merged BRESP. It handles one transaction at a time.

---
 rtl/noc_resp_merge.sv | 237 +++++++++++++++++++++++
 tb/tb_noc_resp_merge.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_resp_merge.sv
// NMU response reassembler: merges split NoC read beats and write
// responses back into one in-order AXI burst with a single last/resp.
module noc_resp_merge #(
  parameter int DATA_WIDTH = 128,
  parameter int ID_WIDTH   = 4,
  parameter int BUF_DEPTH  = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst_n,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic                  desc_is_write,
  input  logic                  desc_split,
  input  logic [7:0]            desc_len0,
  input  logic [7:0]            desc_len1,
  input  logic [ID_WIDTH-1:0]   desc_id0,
  input  logic [ID_WIDTH-1:0]   desc_id1,
  input  logic                  noc_rvalid,
  output logic                  noc_rready,
  input  logic [ID_WIDTH-1:0]   noc_rsrc,
  input  logic [DATA_WIDTH-1:0] noc_rdata,
  input  logic [1:0]            noc_rresp,
  input  logic                  noc_rlast,
  input  logic                  noc_bvalid,
  output logic                  noc_bready,
  input  logic [ID_WIDTH-1:0]   noc_bsrc,
  input  logic [1:0]            noc_bresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  output logic [1:0]            s_bresp,
  output logic                  proto_err
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, RD_P0, RD_P1, WR_WAIT, B_OUT
  } state_t;

  state_t state_q, state_d;

  logic                split_q;
  logic [7:0]          len0_q, len1_q;
  logic [ID_WIDTH-1:0] id0_q, id1_q;
  logic [7:0]          cnt0_q, cnt0_d;
  logic [7:0]          cnt1_q, cnt1_d;
  logic [7:0]          acc1_q, acc1_d;
  logic                got0_q, got0_d;
  logic                got1_q, got1_d;
  logic [1:0]          bacc_q, bacc_d;
  logic [1:0]          bresp_d;
  logic                bvalid_d, perr_d;
  logic [AW:0]         wp_q, wp_d, rp_q, rp_d;
  logic [EW-1:0]       mem [BUF_DEPTH];
  logic [EW-1:0]       head;
  logic                push, pop, take1;
  logic                fifo_empty, fifo_full;
  logic                src0, src1, b0, b1;

  // EXOKAY+OKAY degrades to OKAY; otherwise the worst response wins.
  function automatic logic [1:0] merge_resp(
    input logic [1:0] a,
    input logic [1:0] b
  );
    if (!a[1] && !b[1] && (a[0] ^ b[0]))
      return 2'b00;
    return (a > b) ? a : b;
  endfunction

  assign desc_ready = (state_q == IDLE);
  assign fifo_empty = (wp_q == rp_q);
  assign fifo_full  = (wp_q[AW] != rp_q[AW]) &&
                      (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head = mem[rp_q[AW-1:0]];
  assign src0 = noc_rvalid && (noc_rsrc == id0_q);
  assign src1 = noc_rvalid && split_q && (noc_rsrc == id1_q);
  assign b0   = (noc_bsrc == id0_q) && !got0_q;
  assign b1   = split_q && (noc_bsrc == id1_q) && !got1_q;

  always_comb begin
    state_d    = state_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
    acc1_d     = acc1_q;
    got0_d     = got0_q;
    got1_d     = got1_q;
    bacc_d     = bacc_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    bvalid_d   = s_bvalid;
    bresp_d    = s_bresp;
    perr_d     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    take1      = 1'b0;
    noc_rready = 1'b0;
    noc_bready = 1'b0;
    s_rvalid   = 1'b0;
    s_rdata    = noc_rdata;
    s_rresp    = noc_rresp;
    s_rlast    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (desc_valid) begin
          state_d = desc_is_write ? WR_WAIT : RD_P0;
          cnt0_d  = '0;
          cnt1_d  = '0;
          acc1_d  = '0;
          got0_d  = 1'b0;
          got1_d  = 1'b0;
          bacc_d  = '0;
          wp_d    = '0;
          rp_d    = '0;
        end
      end
      RD_P0: begin
        if (src0) begin
          s_rvalid   = 1'b1;
          s_rlast    = !split_q && (cnt0_q == len0_q);
          noc_rready = s_rready;
          if (s_rready) begin
            cnt0_d = cnt0_q + 8'd1;
            perr_d = noc_rlast != (cnt0_q == len0_q);
            if (cnt0_q == len0_q)
              state_d = split_q ? RD_P1 : IDLE;
          end
        end else if (src1) begin
          noc_rready = !fifo_full;
          push       = !fifo_full;
        end
      end
      RD_P1: begin
        if (!fifo_empty) begin
          s_rvalid   = 1'b1;
          s_rdata    = head[EW-1:2];
          s_rresp    = head[1:0];
          pop        = s_rready;
          noc_rready = src1 && !fifo_full;
          push       = src1 && !fifo_full;
        end else if (src1) begin
          s_rvalid   = 1'b1;
          noc_rready = s_rready;
          take1      = s_rready;
        end
        s_rlast = s_rvalid && (cnt1_q == len1_q);
        if (s_rvalid && s_rready) begin
          cnt1_d = cnt1_q + 8'd1;
          if (cnt1_q == len1_q)
            state_d = IDLE;
        end
      end
      WR_WAIT: begin
        noc_bready = b0 || b1;
        if (noc_bvalid && (b0 || b1)) begin
          got0_d = got0_q || b0;
          got1_d = got1_q || !b0;
          bacc_d = (got0_q || got1_q) ?
                   merge_resp(bacc_q, noc_bresp) : noc_bresp;
        end
        if (got0_d && (got1_d || !split_q)) begin
          bvalid_d = 1'b1;
          bresp_d  = bacc_d;
          state_d  = B_OUT;
        end
      end
      B_OUT: begin
        if (s_bready) begin
          bvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // part1 beats are indexed on arrival, not on output
    if (push || take1) begin
      acc1_d = acc1_q + 8'd1;
      perr_d = noc_rlast != (acc1_q == len1_q);
    end
    if (push) wp_d = wp_q + PTR_ONE;
    if (pop)  rp_d = rp_q + PTR_ONE;
  end

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_q   <= IDLE;
      split_q   <= 1'b0;
      len0_q    <= '0;
      len1_q    <= '0;
      id0_q     <= '0;
      id1_q     <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      acc1_q    <= '0;
      got0_q    <= 1'b0;
      got1_q    <= 1'b0;
      bacc_q    <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= '0;
      proto_err <= 1'b0;
    end else begin
      if (desc_valid && desc_ready) begin
        split_q <= desc_split;
        len0_q  <= desc_len0;
        len1_q  <= desc_split ? desc_len1 : 8'd0;
        id0_q   <= desc_id0;
        id1_q   <= desc_id1;
      end
      state_q   <= state_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      acc1_q    <= acc1_d;
      got0_q    <= got0_d;
      got1_q    <= got1_d;
      bacc_q    <= bacc_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      s_bvalid  <= bvalid_d;
      s_bresp   <= bresp_d;
      proto_err <= perr_d;
    end
  end

  always_ff @(posedge axi_clk) begin
    if (push)
      mem[wp_q[AW-1:0]] <= {noc_rdata, noc_rresp};
  end

endmodule

// File: tb/tb_noc_resp_merge.sv
// Randomized self-checking bench for noc_resp_merge: read reorder,
// backpressure, FIFO full, rlast errors, write merge and reset abort.
module tb_noc_resp_merge;

  localparam int DW = 128;
  localparam int IW = 4;
  localparam int BD = 4;

  logic          axi_clk = 0;
  logic          axi_rst_n = 0;
  logic          desc_valid = 0, desc_ready;
  logic          desc_is_write = 0, desc_split = 0;
  logic [7:0]    desc_len0 = 0, desc_len1 = 0;
  logic [IW-1:0] desc_id0 = 0, desc_id1 = 0;
  logic          noc_rvalid = 0, noc_rready;
  logic [IW-1:0] noc_rsrc = 0;
  logic [DW-1:0] noc_rdata = 0;
  logic [1:0]    noc_rresp = 0;
  logic          noc_rlast = 0;
  logic          noc_bvalid = 0, noc_bready;
  logic [IW-1:0] noc_bsrc = 0;
  logic [1:0]    noc_bresp = 0;
  logic          s_rvalid, s_rready = 0;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rlast;
  logic          s_bvalid, s_bready = 0;
  logic [1:0]    s_bresp;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic          l;
  } beat_t;

  always #5 axi_clk = ~axi_clk;

  noc_resp_merge #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .BUF_DEPTH(BD)) dut (
    .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_is_write(desc_is_write), .desc_split(desc_split),
    .desc_len0(desc_len0), .desc_len1(desc_len1),
    .desc_id0(desc_id0), .desc_id1(desc_id1),
    .noc_rvalid(noc_rvalid), .noc_rready(noc_rready),
    .noc_rsrc(noc_rsrc), .noc_rdata(noc_rdata),
    .noc_rresp(noc_rresp), .noc_rlast(noc_rlast),
    .noc_bvalid(noc_bvalid), .noc_bready(noc_bready),
    .noc_bsrc(noc_bsrc), .noc_bresp(noc_bresp),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .proto_err(proto_err)
  );

  // Reference merge: OKAY/EXOKAY pair gives OKAY, otherwise worst wins.
  function automatic logic [1:0] ref_merge(input logic [1:0] a,
                                           input logic [1:0] b);
    if (a inside {2'd0, 2'd1} && b inside {2'd0, 2'd1} && a != b)
      return 2'd0;
    return (a > b) ? a : b;
  endfunction

  task automatic send_desc(input logic wr, input logic sp,
                           input logic [7:0] l0, input logic [7:0] l1,
                           input logic [IW-1:0] i0,
                           input logic [IW-1:0] i1);
    @(negedge axi_clk);
    desc_valid = 1; desc_is_write = wr; desc_split = sp;
    desc_len0 = l0; desc_len1 = l1; desc_id0 = i0; desc_id1 = i1;
    #1;
    checks++;
    if (desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL desc_ready got %b exp 1", desc_ready);
    end
    @(posedge axi_clk);
    #1 desc_valid = 0;
  endtask

  // stall: 0 always ready, 1 random, 2 five-cycle hold after 2 beats
  task automatic run_read(input logic sp, input logic [7:0] l0,
                          input logic [7:0] l1, input logic [IW-1:0] i0,
                          input logic [IW-1:0] i1, input int stall,
                          input bit bad_last, input int prefill,
                          input int exp_pref);
    beat_t p0[$], p1[$], ex[$];
    beat_t b;
    int cyc = 0, outn = 0, pe = 0, pacc = 0, sc = 0, exp_pe;
    bit use1;
    logic prv_v = 0, prv_r = 1;
    logic [DW-1:0] prv_d = '0;
    for (int i = 0; i <= int'(l0); i++) begin
      b.d = {$urandom, $urandom, $urandom, $urandom};
      b.r = 2'($urandom_range(0, 3));
      b.l = bad_last ? 1'b0 : (i == int'(l0));
      p0.push_back(b);
      b.l = !sp && (i == int'(l0));
      ex.push_back(b);
    end
    if (sp) begin
      for (int i = 0; i <= int'(l1); i++) begin
        b.d = {$urandom, $urandom, $urandom, $urandom};
        b.r = 2'($urandom_range(0, 3));
        b.l = bad_last ? 1'b0 : (i == int'(l1));
        p1.push_back(b);
        b.l = (i == int'(l1));
        ex.push_back(b);
      end
    end
    exp_pe = bad_last ? (sp ? 2 : 1) : 0;
    send_desc(0, sp, l0, l1, i0, i1);
    while (ex.size() > 0 && cyc < 3000) begin
      @(negedge axi_clk);
      cyc++;
      if (cyc <= prefill && p1.size() > 0) use1 = 1;
      else if (p0.size() == 0) use1 = 1;
      else if (p1.size() == 0) use1 = 0;
      else use1 = bit'($urandom_range(0, 1));
      noc_rvalid = 0;
      if (use1 && p1.size() > 0) begin
        noc_rvalid = 1; noc_rsrc = i1; noc_rdata = p1[0].d;
        noc_rresp = p1[0].r; noc_rlast = p1[0].l;
      end else if (!use1 && p0.size() > 0) begin
        noc_rvalid = 1; noc_rsrc = i0; noc_rdata = p0[0].d;
        noc_rresp = p0[0].r; noc_rlast = p0[0].l;
      end
      if (stall == 0) s_rready = 1;
      else if (stall == 1) s_rready = ($urandom_range(0, 3) != 0);
      else if (outn >= 2 && sc < 5) begin
        s_rready = 0; sc++;
      end else s_rready = 1;
      #1;
      if (!sp && !s_rready) begin
        checks++;
        if (noc_rready !== 1'b0) begin
          errors++;
          $display("FAIL stall_rready got %b exp 0", noc_rready);
        end
      end
      if (!sp && prv_v && !prv_r) begin
        checks++;
        if (s_rvalid !== 1'b1 || s_rdata !== prv_d) begin
          errors++;
          $display("FAIL hold got v=%b %h exp v=1 %h",
                   s_rvalid, s_rdata, prv_d);
        end
      end
      if (s_rvalid && s_rready) begin
        checks++;
        if ({s_rdata, s_rresp, s_rlast} !== {ex[0].d, ex[0].r, ex[0].l})
        begin
          errors++;
          $display("FAIL rd_beat%0d got %h/%0d/%b exp %h/%0d/%b", outn,
                   s_rdata, s_rresp, s_rlast, ex[0].d, ex[0].r, ex[0].l);
        end
        void'(ex.pop_front());
        outn++;
      end
      if (noc_rvalid && noc_rready) begin
        if (use1) begin
          void'(p1.pop_front());
          if (cyc <= prefill) pacc++;
        end else void'(p0.pop_front());
      end
      if (proto_err === 1'b1) pe++;
      prv_v = s_rvalid; prv_r = s_rready; prv_d = s_rdata;
    end
    checks++;
    if (ex.size() != 0) begin
      errors++;
      $display("FAIL rd_timeout got %0d beats left exp 0", ex.size());
    end
    @(negedge axi_clk);
    noc_rvalid = 0; s_rready = 0;
    #1;
    if (proto_err === 1'b1) pe++;
    checks++;
    if (desc_ready !== 1'b1 || s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_done got ready=%b v=%b exp 1/0",
               desc_ready, s_rvalid);
    end
    checks++;
    if (pe != exp_pe) begin
      errors++;
      $display("FAIL proto_err got %0d pulses exp %0d", pe, exp_pe);
    end
    if (exp_pref >= 0) begin
      checks++;
      if (pacc != exp_pref) begin
        errors++;
        $display("FAIL prefill got %0d exp %0d", pacc, exp_pref);
      end
    end
  endtask

  task automatic run_write(input logic sp, input logic [1:0] r0,
                           input logic [1:0] r1, input logic [IW-1:0] i0,
                           input logic [IW-1:0] i1, input bit first1);
    logic [1:0] expr;
    logic [IW-1:0] srcs[2];
    logic [1:0] rs[2];
    int n;
    expr = sp ? ref_merge(r0, r1) : r0;
    n = sp ? 2 : 1;
    if (sp && first1) begin
      srcs[0] = i1; rs[0] = r1; srcs[1] = i0; rs[1] = r0;
    end else begin
      srcs[0] = i0; rs[0] = r0; srcs[1] = i1; rs[1] = r1;
    end
    send_desc(1, sp, 0, 0, i0, i1);
    @(negedge axi_clk);
    noc_bvalid = 1; noc_bsrc = 4'hF; noc_bresp = 2'd3;
    #1;
    checks++;
    if (noc_bready !== 1'b0) begin
      errors++;
      $display("FAIL bready_foreign got %b exp 0", noc_bready);
    end
    for (int k = 0; k < n; k++) begin
      @(negedge axi_clk);
      noc_bvalid = 1; noc_bsrc = srcs[k]; noc_bresp = rs[k];
      #1;
      checks++;
      if (noc_bready !== 1'b1 || s_bvalid !== 1'b0) begin
        errors++;
        $display("FAIL b_accept%0d got rdy=%b bv=%b exp 1/0",
                 k, noc_bready, s_bvalid);
      end
    end
    @(negedge axi_clk);
    noc_bvalid = 0; s_bready = 0;
    #1;
    checks++;
    if (s_bvalid !== 1'b1 || s_bresp !== expr) begin
      errors++;
      $display("FAIL bresp got v=%b %0d exp v=1 %0d",
               s_bvalid, s_bresp, expr);
    end
    repeat (2) begin
      @(negedge axi_clk);
      #1;
      checks++;
      if (s_bvalid !== 1'b1 || s_bresp !== expr) begin
        errors++;
        $display("FAIL b_hold got v=%b %0d exp v=1 %0d",
                 s_bvalid, s_bresp, expr);
      end
    end
    @(negedge axi_clk);
    s_bready = 1;
    @(negedge axi_clk);
    s_bready = 0;
    #1;
    checks++;
    if (s_bvalid !== 1'b0 || desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_done got v=%b rdy=%b exp 0/1", s_bvalid, desc_ready);
    end
  endtask

  task automatic test_reset;
    axi_rst_n = 0;
    repeat (2) @(negedge axi_clk);
    #1;
    checks++;
    if ({desc_ready, s_rvalid, s_bvalid, noc_rready, noc_bready, proto_err}
        !== 6'b100000) begin
      errors++;
      $display("FAIL reset got %b%b%b%b%b%b exp 100000", desc_ready,
               s_rvalid, s_bvalid, noc_rready, noc_bready, proto_err);
    end
    @(negedge axi_clk);
    axi_rst_n = 1;
  endtask

  task automatic test_nonsplit;
    run_read(0, 8'd3, 8'd0, 4'd1, 4'd0, 0, 0, 0, -1);
  endtask

  task automatic test_split_order;
    run_read(1, 8'd1, 8'd2, 4'd1, 4'd3, 0, 0, 6, 3);
  endtask

  task automatic test_fifo_full;
    run_read(1, 8'd1, 8'd5, 4'd1, 4'd3, 0, 0, 12, 4);
  endtask

  task automatic test_backpressure;
    run_read(0, 8'd7, 8'd0, 4'd2, 4'd0, 2, 0, 0, -1);
    run_read(1, 8'd3, 8'd6, 4'd2, 4'd5, 1, 0, 0, -1);
  endtask

  task automatic test_proto_err;
    run_read(0, 8'd2, 8'd0, 4'd4, 4'd0, 0, 1, 0, -1);
    run_read(1, 8'd1, 8'd2, 4'd4, 4'd6, 1, 1, 0, -1);
  endtask

  task automatic test_write_merge;
    run_write(1, 2'd2, 2'd0, 4'd1, 4'd3, 1);
    run_write(1, 2'd1, 2'd0, 4'd1, 4'd3, 0);
    run_write(0, 2'd1, 2'd3, 4'd7, 4'd8, 0);
    run_write(1, 2'd3, 2'd1, 4'd2, 4'd9, 1);
  endtask

  task automatic test_reset_mid;
    send_desc(0, 1, 8'd1, 8'd2, 4'd1, 4'd3);
    repeat (2) begin
      @(negedge axi_clk);
      noc_rvalid = 1; noc_rsrc = 4'd3; noc_rlast = 0;
      noc_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge axi_clk);
    noc_rsrc = 4'd1; s_rready = 1;
    #1;
    checks++;
    if (s_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL pre_abort got v=%b exp 1", s_rvalid);
    end
    #2 axi_rst_n = 0;
    #1;
    checks++;
    if ({s_rvalid, noc_rready, s_bvalid, noc_bready, desc_ready}
        !== 5'b00001) begin
      errors++;
      $display("FAIL abort got %b%b%b%b%b exp 00001", s_rvalid,
               noc_rready, s_bvalid, noc_bready, desc_ready);
    end
    noc_rvalid = 0; s_rready = 0;
    @(negedge axi_clk);
    axi_rst_n = 1;
    run_read(0, 8'd0, 8'd0, 4'd5, 4'd0, 0, 0, 0, -1);
  endtask

  task automatic test_random;
    logic [IW-1:0] a, c;
    for (int t = 0; t < 8; t++) begin
      a = IW'($urandom_range(0, 14));
      c = IW'((int'(a) + 1 + $urandom_range(0, 13)) % 15);
      run_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
               8'($urandom_range(0, 7)), a, c, 1, 0, 0, -1);
    end
    for (int t = 0; t < 4; t++) begin
      a = IW'($urandom_range(0, 14));
      c = IW'((int'(a) + 1 + $urandom_range(0, 13)) % 15);
      run_write(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)), a, c, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_nonsplit();
    test_split_order();
    test_fifo_full();
    test_backpressure();
    test_proto_err();
    test_write_merge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
